vga_disp_timer: RTL and testbench



---
 rtl/vga_pkg.sv | 30 +++
 rtl/vga_disp_timer_axis.sv | 59 +++++
 rtl/vga_disp_timer.sv | 192 +++++++++++++++++++
 tb/tb_vga_disp_timer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types and timing helpers for the VGA display timer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vga_pkg;

  // Per-line render handshake with the line-buffer engines.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RENDER = 2'd1,
    ST_READY  = 2'd2
  } render_state_e;

  // Full period of one axis, in pixels (H) or lines (V).
  function automatic int axis_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // First count at which sync is asserted.
  function automatic int axis_sync_start(input int active, input int fp);
    return active + fp;
  endfunction

  // First count after sync is released.
  function automatic int axis_sync_end(input int active, input int fp,
                                       input int sync);
    return active + fp + sync;
  endfunction

endpackage

// File: rtl/vga_disp_timer_axis.sv
// One timing axis: wrapping counter with sync and active-region decode.
// Latency: count registered, wrap/sync/active combinational from count.
// Backpressure: none; advances on step_i, clear_i forces origin.
//
// Ports: clk_i/reset_i (sync, active-high), step_i advance, clear_i to 0,
//        count_o current position, wrap_o last position being stepped,
//        sync_o sync at POL level, active_o inside the visible region.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter bit POL    = 1'b0,
  parameter int W      = 11
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         step_i,
  input  logic         clear_i,
  output logic [W-1:0] count_o,
  output logic         wrap_o,
  output logic         sync_o,
  output logic         active_o
);

  localparam logic [W-1:0] LAST   = W'(axis_total(ACTIVE, FP, SYNC, BP) - 1);
  localparam logic [W-1:0] SYNC_S = W'(axis_sync_start(ACTIVE, FP));
  localparam logic [W-1:0] SYNC_E = W'(axis_sync_end(ACTIVE, FP, SYNC));
  localparam logic [W-1:0] ACT    = W'(ACTIVE);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign wrap_o = step_i & (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (step_i) begin
      count_d = wrap_o ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o  = count_q;
  assign sync_o   = ((count_q >= SYNC_S) && (count_q < SYNC_E)) ? POL : ~POL;
  assign active_o = (count_q < ACT);

endmodule

// File: rtl/vga_disp_timer.sv
// VGA mode timer: pixel strobe, H/V counters, syncs, blank and the per-line
// render/swap handshake with the line-buffer engines.
// Latency: counters/FSM registered; syncs, blank, pulses decode in the cycle
// the counters show the event. Backpressure: none; a late render_done
// repeats the old line (underrun) instead of stalling timing.
//
// Ports: clk/reset (sync, active-high), enable (0 parks at origin),
//        pix_ce/hcount/vcount timing, VGA_* panel signals,
//        render_start/render_line/render_done/swap engine handshake,
//        underrun (+underrun_clr), frame_cnt, vblank_irq.
module vga_disp_timer
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int HW       = 11,
  parameter int VW       = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  output logic          pix_ce,
  output logic [HW-1:0] hcount,
  output logic [VW-1:0] vcount,
  output logic          VGA_CLK,
  output logic          VGA_HS,
  output logic          VGA_VS,
  output logic          VGA_BLANK_n,
  output logic          render_start,
  output logic [VW-1:0] render_line,
  input  logic          render_done,
  output logic          swap,
  output logic          underrun,
  input  logic          underrun_clr,
  output logic [15:0]   frame_cnt,
  output logic          vblank_irq
);

  localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PH_HALF = PW'(CLK_DIV / 2);

  localparam int VTOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_ACT_LAST = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] V_LAST     = VW'(VTOTAL - 1);

  logic [PW-1:0]  phase_q, phase_d;
  logic           run_q;
  logic           adv;
  logic           h_wrap, v_wrap;
  logic           h_act, v_act;
  logic           line_start, line_end;
  logic           t_vld;
  logic [VW-1:0]  t_line;
  logic           under_set;
  render_state_e  state_q, state_d;
  logic [VW-1:0]  render_line_q, render_line_d;
  logic           underrun_q, underrun_d;
  logic [15:0]    frame_cnt_q, frame_cnt_d;

  // run_q lags enable by one clock so that the first running cycle shows
  // the origin at phase 0, giving a clean line-start point after enable.
  assign adv    = run_q & enable;
  assign pix_ce = adv & (phase_q == PH_LAST);

  always_comb begin
    phase_d = phase_q;
    if (!enable) begin
      phase_d = '0;
    end else if (run_q) begin
      phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
    end
  end

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP),
    .POL(HS_POL), .W(HW)
  ) u_h (
    .clk_i   (clk),
    .reset_i (reset),
    .step_i  (pix_ce),
    .clear_i (~enable),
    .count_o (hcount),
    .wrap_o  (h_wrap),
    .sync_o  (VGA_HS),
    .active_o(h_act)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP),
    .POL(VS_POL), .W(VW)
  ) u_v (
    .clk_i   (clk),
    .reset_i (reset),
    .step_i  (h_wrap),
    .clear_i (~enable),
    .count_o (vcount),
    .wrap_o  (v_wrap),
    .sync_o  (VGA_VS),
    .active_o(v_act)
  );

  assign line_start  = adv & (phase_q == '0) & (hcount == '0);
  assign line_end    = h_wrap;
  assign vblank_irq  = line_start & (vcount == V_ACT);
  assign VGA_CLK     = run_q & (phase_q >= PH_HALF);
  assign VGA_BLANK_n = run_q & h_act & v_act;

  // Render one line ahead; the last blanking line pre-renders line 0.
  assign t_vld  = (vcount < V_ACT_LAST) | (vcount == V_LAST);
  assign t_line = (vcount == V_LAST) ? '0 : vcount + 1'b1;

  always_comb begin
    state_d      = state_q;
    render_start = 1'b0;
    swap         = 1'b0;
    under_set    = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (line_start && t_vld) begin
            render_start = 1'b1;
            state_d      = ST_RENDER;
          end
        end
        ST_RENDER: begin
          if (line_end) begin
            // Done arriving on the line-end cycle still makes the swap.
            if (render_done) begin
              swap    = 1'b1;
              state_d = ST_IDLE;
            end else begin
              under_set = 1'b1;
            end
          end else if (render_done) begin
            state_d = ST_READY;
          end
        end
        ST_READY: begin
          if (line_end) begin
            swap    = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    render_line_d = render_start ? t_line : render_line_q;
    // A new underrun wins over a same-cycle clear.
    underrun_d    = under_set | (underrun_q & ~underrun_clr);
    frame_cnt_d   = v_wrap ? frame_cnt_q + 16'd1 : frame_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q       <= '0;
      run_q         <= 1'b0;
      state_q       <= ST_IDLE;
      render_line_q <= '0;
      underrun_q    <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      phase_q       <= phase_d;
      run_q         <= enable;
      state_q       <= state_d;
      render_line_q <= render_line_d;
      underrun_q    <= underrun_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  // Line number is valid during the render_start pulse itself.
  assign render_line = render_line_d;
  assign underrun    = underrun_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_disp_timer.sv
module tb_vga_disp_timer;

  localparam int DIV = 4;
  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        render_done;
  logic        underrun_clr = 1'b0;
  logic        pix_ce, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_n;
  logic        render_start, swap, underrun, vblank_irq;
  logic [3:0]  hcount;
  logic [2:0]  vcount, render_line;
  logic [15:0] frame_cnt;

  vga_disp_timer #(
    .CLK_DIV(DIV), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b0), .HW(4), .VW(3)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .pix_ce(pix_ce),
    .hcount(hcount), .vcount(vcount), .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS),
    .VGA_VS(VGA_VS), .VGA_BLANK_n(VGA_BLANK_n), .render_start(render_start),
    .render_line(render_line), .render_done(render_done), .swap(swap),
    .underrun(underrun), .underrun_clr(underrun_clr), .frame_cnt(frame_cnt),
    .vblank_irq(vblank_irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Engine responder knobs.
  int done_delay = 20;
  int slow_line  = -1;
  int slow_delay = 80;
  int dcnt       = 0;

  // Reference model state: time since counters left the origin.
  bit          m_run   = 1'b0;
  int          m_t     = 0;
  int          m_hs    = 0;     // 0 idle, 1 rendering, 2 ready
  bit          m_under = 1'b0;
  logic [15:0] m_frame = '0;
  int          line_q[$];

  int ph, pix, h, v, tl;
  bit ce, ls, le, tv, e_start, e_swap, u_set;

  always @(negedge clk) begin
    if (m_run) begin
      ph  = m_t % DIV;
      pix = m_t / DIV;
      h   = pix % HT;
      v   = (pix / HT) % VT;
    end else begin
      ph = 0; h = 0; v = 0;
    end
    ce = m_run && enable && (ph == DIV - 1);
    ls = m_run && enable && (ph == 0) && (h == 0);
    le = ce && (h == HT - 1);
    tv = (v < VA - 1) || (v == VT - 1);
    tl = (v == VT - 1) ? 0 : v + 1;
    e_start = (m_hs == 0) && ls && tv;
    e_swap  = le && ((m_hs == 2) || ((m_hs == 1) && render_done));
    u_set   = le && (m_hs == 1) && !render_done;

    check_eq("hcount", hcount, h);
    check_eq("vcount", vcount, v);
    check_eq("pix_ce", pix_ce, ce);
    check_eq("VGA_CLK", VGA_CLK, m_run && (ph >= DIV / 2));
    check_eq("VGA_HS", VGA_HS, (h >= HA + HF) && (h < HA + HF + HS));
    check_eq("VGA_VS", VGA_VS, !((v >= VA + VF) && (v < VA + VF + VS)));
    check_eq("BLANK_n", VGA_BLANK_n, m_run && (h < HA) && (v < VA));
    check_eq("render_start", render_start, e_start);
    check_eq("swap", swap, e_swap);
    check_eq("vblank_irq", vblank_irq, ls && (v == VA));
    check_eq("underrun", underrun, m_under);
    check_eq("frame_cnt", frame_cnt, m_frame);

    if (e_start) line_q.push_back(tl);
    if (render_start && line_q.size() != 0)
      check_eq("render_line", render_line, line_q.pop_front());

    if (reset) begin
      m_run = 0; m_t = 0; m_hs = 0; m_under = 0; m_frame = '0;
    end else begin
      if (u_set) m_under = 1;
      else if (underrun_clr) m_under = 0;
      if (le && v == VT - 1) m_frame = m_frame + 16'd1;
      if (!enable) m_hs = 0;
      else case (m_hs)
        0: if (e_start) m_hs = 1;
        1: if (le) begin if (render_done) m_hs = 0; end
           else if (render_done) m_hs = 2;
        2: if (le) m_hs = 0;
        default: m_hs = 0;
      endcase
      if (!enable) begin m_run = 0; m_t = 0; end
      else if (m_run) m_t++;
      else begin m_run = 1; m_t = 0; end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  bit found;

  initial begin
    fork
      begin
        render_done = 1'b0;
        forever begin
          @(posedge clk);
          #2;
          render_done = 1'b0;
          if (dcnt > 0) begin
            dcnt--;
            if (dcnt == 0) render_done = 1'b1;
          end
          if (render_start)
            dcnt = (int'(render_line) == slow_line) ? slow_delay : done_delay;
        end
      end
    join_none

    tick(3);
    reset  = 1'b0;
    enable = 1'b1;
    tick(2 * HT * VT * DIV + 50);

    // Line 2 misses its swap point, completes one line late.
    slow_line = 2;
    tick(460);
    slow_line = -1;
    @(negedge clk);
    check_eq("underrun_sticky", underrun, 1);
    tick(1);
    underrun_clr = 1'b1;
    tick(1);
    underrun_clr = 1'b0;
    @(negedge clk);
    check_eq("underrun_cleared", underrun, 0);

    // Clear held across a new underrun: set wins for that cycle only.
    tick(1);
    underrun_clr = 1'b1;
    slow_line    = 2;
    tick(460);
    slow_line    = -1;
    underrun_clr = 1'b0;
    tick(2);

    // render_done lands exactly on the line-end cycle.
    done_delay = HT * DIV - 1;
    tick(460);
    @(negedge clk);
    check_eq("same_cycle_no_underrun", underrun, 0);
    done_delay = 20;

    // Drop enable mid-line at vcount 2.
    found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (vcount == 3'd2 && hcount == 4'd5) found = 1;
    end
    check_eq("find_mid_line", found, 1);
    @(posedge clk);
    #1;
    enable = 1'b0;
    tick(1);
    @(negedge clk);
    check_eq("drop_hcount", hcount, 0);
    check_eq("drop_vcount", vcount, 0);
    check_eq("drop_blank", VGA_BLANK_n, 0);
    check_eq("drop_frame_kept", frame_cnt, m_frame);
    tick(5);
    enable = 1'b1;
    tick(2 * HT * VT * DIV + 20);

    // Reset mid-line abandons any pending render.
    tick(137);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    @(negedge clk);
    check_eq("reset_frame", frame_cnt, 0);
    tick(HT * VT * DIV + 60);

    @(negedge clk);
    check_eq("scoreboard_drained", line_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
